// File: rtl/gate_trigger_queue.sv
// Serialises one-cycle gate output pulses into a FIFO of gate indices.
// Simultaneous pulses are ordered lowest index first; back-pressure parks them in a pending mask.
module gate_trigger_queue #(
    parameter int N_GATES = 16,
    parameter int DEPTH   = 8,
    localparam int IDX_W  = $clog2(N_GATES)
) (
    input  logic               clk,
    input  logic               logic_reset,
    input  logic [N_GATES-1:0] gate_out,
    input  logic               trig_ready,
    output logic               trig_valid,
    output logic [IDX_W-1:0]   trig_idx,
    output logic               idle,
    output logic               dup_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [N_GATES-1:0] pending;
    logic [N_GATES-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               pop;
    logic               push;

    assign trig_valid = (count != '0);
    assign pop        = trig_valid && trig_ready;
    assign push       = (pending != '0) && ((count != FULL_COUNT) || pop);
    assign trig_idx   = trig_valid ? mem[rd_ptr] : '0;
    assign idle       = (pending == '0) && (count == '0) && (gate_out == '0);

    // Priority pick of the lowest pending bit; only the registered mask is considered.
    always_comb begin
        grant_idx = '0;
        grant     = '0;
        for (int i = N_GATES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
        if (push) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (logic_reset) begin
            pending <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            dup_err <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | gate_out;
            // A pulse on a bit granted this very cycle is a fresh event, not a duplicate.
            if ((gate_out & pending & ~grant) != '0) begin
                dup_err <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (!logic_reset && push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

endmodule
